pipe_in_dac_player: RTL and testbench

- Host-to-board counterpart of the ADC capture path.
- Accepts 16-bit words written by the host through a pipe-in endpoint (ep_write / ep_dataout) and stores them in an on-chip sample buffer.
- Replays the buffer to a DAC code bus at a programmable rate, either one-shot or looped.
- Sits in the ti_clk domain, between the okPipeIn endpoint and the DAC pins. Control comes from wire-in bits; status goes to a wire-out.

---
 rtl/adc_test_pkg.sv | 8 +
 rtl/sample_ram.sv | 18 +
 rtl/pipe_in_dac_player.sv | 91 +++++++++
 tb/tb_pipe_in_dac_player.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_test_pkg.sv
// adc_test_pkg: types and constants shared by the ADC capture and DAC playback paths
package adc_test_pkg;
   localparam int DAC_PRECISION = 10;
   typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_PLAY = 2'd1} state_t;
   function automatic int depth_of(input int addr_width);
      return 2 ** addr_width;
   endfunction
endpackage

// File: rtl/sample_ram.sv
// sample_ram: simple dual-port buffer, one write port and one registered read port
module sample_ram #(
   parameter int ADDR_WIDTH = 10,
   parameter int DATA_WIDTH = 16
) (
   input  logic                  clk,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] waddr,
   input  logic [DATA_WIDTH-1:0] wdata,
   input  logic [ADDR_WIDTH-1:0] raddr,
   output logic [DATA_WIDTH-1:0] q
);
   logic [DATA_WIDTH-1:0] mem [0:2**ADDR_WIDTH-1];
   always_ff @(posedge clk) begin
      if (we) mem[waddr] <= wdata;
      q <= mem[raddr];
   end
endmodule

// File: rtl/pipe_in_dac_player.sv
// pipe_in_dac_player: buffers host pipe-in words and replays them to a DAC bus
// at a programmable rate, one-shot or looped.
module pipe_in_dac_player
   import adc_test_pkg::*;
#(
   parameter int PRECISION  = DAC_PRECISION,
   parameter int ADDR_WIDTH = 10,
   parameter int DIV_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  pipe_wr,
   input  logic [15:0]           pipe_data,
   input  logic                  arm,
   input  logic                  start,
   input  logic                  stop,
   input  logic                  loop_en,
   input  logic [DIV_WIDTH-1:0]  rate_div,
   output logic [PRECISION-1:0]  dac_code,
   output logic                  dac_strobe,
   output logic                  busy,
   output logic [ADDR_WIDTH:0]   sample_count,
   output logic                  overflow,
   output logic                  done
);
   localparam int DEPTH = depth_of(ADDR_WIDTH);
   localparam logic [ADDR_WIDTH:0]   FULL    = (ADDR_WIDTH+1)'(DEPTH);
   localparam logic [ADDR_WIDTH:0]   CNT_ONE = (ADDR_WIDTH+1)'(1);
   localparam logic [ADDR_WIDTH-1:0] PTR_ONE = ADDR_WIDTH'(1);
   localparam logic [DIV_WIDTH-1:0]  DIV_ONE = DIV_WIDTH'(1);

   state_t                state, state_nx;
   logic [ADDR_WIDTH-1:0] rd_ptr, rd_nx;
   logic [DIV_WIDTH-1:0]  div_cnt;
   logic [15:0]           q;
   logic                  prime, playing, wr_ok, go, hit, last;
   logic                  unused_q;

   assign playing  = state == ST_PLAY;
   assign busy     = playing;
   assign wr_ok    = pipe_wr && !arm && !playing && sample_count != FULL;
   assign go       = !playing && !arm && !stop && start && (sample_count != '0 || wr_ok);
   assign hit      = playing && !arm && !stop && !prime && div_cnt >= rate_div;
   assign last     = hit && ({1'b0, rd_ptr} + CNT_ONE) == sample_count;
   assign unused_q = ^q[15:PRECISION];

   // The RAM reads at the next pointer so its output always holds mem[rd_ptr];
   // the one-cycle prime after start covers a word written on the start edge.
   always_comb begin
      rd_nx    = (arm || go || last) ? '0 : hit ? rd_ptr + PTR_ONE : rd_ptr;
      state_nx = arm ? ST_IDLE
               : (playing && (stop || (last && !loop_en))) ? ST_IDLE
               : go ? ST_PLAY : state;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nx;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_ptr       <= '0;
         div_cnt      <= '0;
         prime        <= 1'b0;
         dac_code     <= '0;
         dac_strobe   <= 1'b0;
         sample_count <= '0;
         overflow     <= 1'b0;
         done         <= 1'b0;
      end else begin
         rd_ptr       <= rd_nx;
         prime        <= go;
         div_cnt      <= (go || hit || !playing) ? '0 : prime ? div_cnt : div_cnt + DIV_ONE;
         dac_strobe   <= hit;
         if (hit) dac_code <= q[PRECISION-1:0];
         sample_count <= arm ? '0 : wr_ok ? sample_count + CNT_ONE : sample_count;
         overflow     <= !arm && (overflow || (pipe_wr && !wr_ok));
         done         <= !arm && !go && (done || (last && !loop_en));
      end
   end

   sample_ram #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(16)) u_ram (
      .clk   (clk),
      .we    (wr_ok),
      .waddr (sample_count[ADDR_WIDTH-1:0]),
      .wdata (pipe_data),
      .raddr (rd_nx),
      .q     (q)
   );
endmodule

// File: tb/tb_pipe_in_dac_player.sv
// tb_pipe_in_dac_player: vector table, directed corner sequences and randomized
// one-shot runs checked against an arithmetic model of strobe times and codes.
module tb_pipe_in_dac_player;
   localparam int PREC  = 10;
   localparam int AW    = 10;
   localparam int DW    = 16;
   localparam int DEPTH = 1 << AW;

   logic            clk = 1'b0, rst_n = 1'b0;
   logic            pipe_wr = 1'b0, arm = 1'b0, start = 1'b0, stop = 1'b0, loop_en = 1'b0;
   logic [15:0]     pipe_data = '0;
   logic [DW-1:0]   rate_div = '0;
   logic [PREC-1:0] dac_code;
   logic            dac_strobe, busy, overflow, done;
   logic [AW:0]     sample_count;

   always #5 clk = ~clk;

   pipe_in_dac_player #(.PRECISION(PREC), .ADDR_WIDTH(AW), .DIV_WIDTH(DW)) dut (
      .clk(clk), .rst_n(rst_n), .pipe_wr(pipe_wr), .pipe_data(pipe_data), .arm(arm),
      .start(start), .stop(stop), .loop_en(loop_en), .rate_div(rate_div),
      .dac_code(dac_code), .dac_strobe(dac_strobe), .busy(busy),
      .sample_count(sample_count), .overflow(overflow), .done(done)
   );

   typedef struct {
      logic            start;
      logic            strobe;
      logic [PREC-1:0] code;
      logic            busy;
      logic            done;
   } vec_t;

   int              n_pass = 0, n_total = 0;
   int              q_edge[$];
   logic [PREC-1:0] q_code[$];
   logic [15:0]     words[$];
   vec_t            tv[7];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic load(input logic [15:0] w);
      pipe_data = w;
      pipe_wr = 1'b1;
      tick();
      pipe_wr = 1'b0;
   endtask

   task automatic do_arm();
      arm = 1'b1;
      tick();
      arm = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   // Edge indices count from 1 at the first edge after the call.
   task automatic collect(input int max_edges, input int want);
      q_edge.delete();
      q_code.delete();
      for (int e = 1; e <= max_edges; e++) begin
         tick();
         if (dac_strobe) begin
            q_edge.push_back(e);
            q_code.push_back(dac_code);
         end
         if (want > 0 ? q_edge.size() >= want : !busy) return;
      end
      n_total++;
      $display("FAIL collect: timeout after %0d edges, %0d strobes seen", max_edges, q_edge.size());
   endtask

   function automatic int exp_edge(input int rd, input int i);
      return (rd + 2) + i * (rd + 1);
   endfunction

   function automatic logic [PREC-1:0] exp_code(input int i);
      logic [15:0] w;
      w = words[i % words.size()];
      return w[PREC-1:0];
   endfunction

   initial begin
      int n, rd, coinc, quiet;
      logic [15:0] w;
      tv[0] = '{1'b1, 1'b0, 10'h000, 1'b1, 1'b0};
      tv[1] = '{1'b0, 1'b0, 10'h000, 1'b1, 1'b0};
      tv[2] = '{1'b0, 1'b1, 10'h001, 1'b1, 1'b0};
      tv[3] = '{1'b0, 1'b1, 10'h002, 1'b1, 1'b0};
      tv[4] = '{1'b0, 1'b1, 10'h3FF, 1'b1, 1'b0};
      tv[5] = '{1'b0, 1'b1, 10'h005, 1'b0, 1'b1};
      tv[6] = '{1'b0, 1'b0, 10'h005, 1'b0, 1'b1};

      tick();
      chk("reset_code", dac_code, 0);
      chk("reset_strobe", dac_strobe, 0);
      chk("reset_busy", busy, 0);
      chk("reset_count", sample_count, 0);
      chk("reset_flags", {overflow, done}, 0);
      rst_n = 1'b1;
      tick();

      // one-shot, rate_div = 0, upper data bits ignored
      words = '{16'h0001, 16'h0002, 16'h03FF, 16'hFC05};
      foreach (words[i]) load(words[i]);
      chk("load4_count", sample_count, 4);
      for (int i = 0; i < 7; i++) begin
         start = tv[i].start;
         tick();
         start = 1'b0;
         chk($sformatf("vec%0d_strobe", i), dac_strobe, tv[i].strobe);
         chk($sformatf("vec%0d_code", i), dac_code, tv[i].code);
         chk($sformatf("vec%0d_busy", i), busy, tv[i].busy);
         chk($sformatf("vec%0d_done", i), done, tv[i].done);
      end

      // looped at rate_div = 3, then stop
      rate_div = 3;
      loop_en = 1'b1;
      pulse_start();
      chk("loop_done_cleared", done, 0);
      collect(100, 12);
      chk("loop_nstrobes", q_edge.size(), 12);
      foreach (q_edge[i]) begin
         chk($sformatf("loop_edge%0d", i), q_edge[i], exp_edge(3, i));
         chk($sformatf("loop_code%0d", i), q_code[i], exp_code(i));
      end
      stop = 1'b1;
      tick();
      stop = 1'b0;
      chk("stop_busy", busy, 0);
      quiet = 0;
      for (int i = 0; i < 20; i++) begin
         tick();
         quiet += int'(dac_strobe);
      end
      chk("stop_no_strobe", quiet, 0);
      chk("stop_code_hold", dac_code, 10'h005);
      chk("stop_done", done, 0);

      // overfill, arm, empty start
      do_arm();
      for (int i = 0; i < DEPTH + 2; i++) load(16'(i));
      chk("full_count", sample_count, DEPTH);
      chk("full_overflow", overflow, 1);
      do_arm();
      chk("arm_count", sample_count, 0);
      chk("arm_overflow", overflow, 0);
      chk("arm_code_hold", dac_code, 10'h005);
      pulse_start();
      chk("empty_start_busy", busy, 0);
      tick();
      chk("empty_start_strobe", {busy, dac_strobe}, 0);

      // write during play, then rate change 1 -> 4
      words = '{16'h0011, 16'h0022, 16'h0033, 16'h0044};
      foreach (words[i]) load(words[i]);
      rate_div = 1;
      loop_en = 1'b1;
      pulse_start();
      load(16'h0123);
      chk("play_wr_overflow", overflow, 1);
      chk("play_wr_count", sample_count, 4);
      collect(100, 4);
      foreach (q_code[i]) chk($sformatf("r1_code%0d", i), q_code[i], exp_code(i));
      for (int i = 1; i < q_edge.size(); i++)
         chk($sformatf("r1_gap%0d", i), q_edge[i] - q_edge[i-1], 2);
      rate_div = 4;
      collect(100, 4);
      chk("r4_first", q_edge.size() > 0 ? q_edge[0] : -1, 5);
      foreach (q_code[i]) chk($sformatf("r4_code%0d", i), q_code[i], exp_code(i));
      for (int i = 1; i < q_edge.size(); i++)
         chk($sformatf("r4_gap%0d", i), q_edge[i] - q_edge[i-1], 5);
      arm = 1'b1;
      start = 1'b1;
      tick();
      arm = 1'b0;
      start = 1'b0;
      chk("arm_start_busy", busy, 0);
      chk("arm_start_count", sample_count, 0);
      tick();
      chk("arm_start_idle", busy, 0);

      // randomized one-shot runs, last word sometimes written with start
      for (int it = 0; it < 8; it++) begin
         do_arm();
         n = $urandom_range(2, 8);
         rd = $urandom_range(0, 3);
         coinc = $urandom_range(0, 1);
         rate_div = DW'(rd);
         loop_en = 1'b0;
         words.delete();
         for (int i = 0; i < n; i++) begin
            w = 16'($urandom);
            words.push_back(w);
            if (i == n - 1 && coinc != 0) begin
               pipe_data = w;
               pipe_wr = 1'b1;
               start = 1'b1;
               tick();
               pipe_wr = 1'b0;
               start = 1'b0;
            end else load(w);
         end
         if (coinc == 0) pulse_start();
         collect(200, 0);
         chk($sformatf("rnd%0d_n", it), q_edge.size(), n);
         foreach (q_edge[i]) begin
            chk($sformatf("rnd%0d_edge%0d", it, i), q_edge[i], exp_edge(rd, i));
            chk($sformatf("rnd%0d_code%0d", it, i), q_code[i], exp_code(i));
         end
         chk($sformatf("rnd%0d_flags", it), {busy, done, overflow}, 3'b010);
         chk($sformatf("rnd%0d_count", it), sample_count, n);
      end

      // asynchronous reset mid-playback
      do_arm();
      load(16'h0155);
      load(16'h02AA);
      rate_div = 0;
      loop_en = 1'b1;
      pulse_start();
      tick();
      tick();
      tick();
      chk("pre_reset_busy", busy, 1);
      #2 rst_n = 1'b0;
      #1;
      chk("async_code", dac_code, 0);
      chk("async_strobe_busy", {dac_strobe, busy}, 0);
      chk("async_count", sample_count, 0);
      chk("async_flags", {overflow, done}, 0);
      tick();
      rst_n = 1'b1;
      tick();
      chk("post_reset_busy", busy, 0);
      chk("post_reset_count", sample_count, 0);
      chk("post_reset_strobe", dac_strobe, 0);

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
